// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the utility-load scheduler: load indices, priority order, per-load state.
// Latency: none (constants, types and a pure helper function).
// Backpressure: not applicable.
package load_scheduler_pkg;

  localparam int NUM_LOADS = 4;

  typedef logic [1:0] load_idx_t;

  localparam load_idx_t LD_HEAT   = 2'd0;
  localparam load_idx_t LD_COOL   = 2'd1;
  localparam load_idx_t LD_PUMP   = 2'd2;
  localparam load_idx_t LD_SPRINK = 2'd3;

  // Order in which off-and-ready loads are offered free budget slots, highest first.
  localparam load_idx_t PRIO_ORDER [NUM_LOADS] = '{LD_PUMP, LD_HEAT, LD_COOL, LD_SPRINK};

  // Dwell state of one load, decoded from its grant bit and its dwell timer flags.
  typedef enum logic [1:0] {
    OFF_HOLD  = 2'd0,
    OFF_READY = 2'd1,
    ON_HOLD   = 2'd2,
    ON_FREE   = 2'd3
  } load_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/load_scheduler_dwell_timer.sv
// Per-load dwell timer: counts consecutive granted / not-granted cycles, both saturating.
// Latency: counters update on the edge that registers the grant they track; flags are registered.
// Backpressure: none; follows the granted level every cycle.
//
// Ports:
//   clk, reset    clock and async active-low reset
//   granted       grant value being registered at this edge
//   on_done       on-counter has reached MIN_ON
//   off_done      off-counter has reached MIN_OFF
module load_dwell_timer #(
  parameter int CNT_W   = 4,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic granted,
  output logic on_done,
  output logic off_done
);

  localparam logic [CNT_W-1:0] ON_MAX  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] OFF_MAX = CNT_W'(MIN_OFF);

  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;

  // Off-counter starts saturated so a load is grantable on the very first edge
  // out of reset: no off-dwell is owed for time spent in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      on_cnt  <= '0;
      off_cnt <= OFF_MAX;
    end else if (granted) begin
      off_cnt <= '0;
      if (on_cnt != ON_MAX) on_cnt <= on_cnt + CNT_W'(1);
    end else begin
      on_cnt <= '0;
      if (off_cnt != OFF_MAX) off_cnt <= off_cnt + CNT_W'(1);
    end
  end

  assign on_done  = (on_cnt == ON_MAX);
  assign off_done = (off_cnt == OFF_MAX);

endmodule

// File: rtl/load_scheduler.sv
// Supply-budget arbiter for heater, cooler, pump and sprinkler with dwell, exclusion and fire override.
// Latency: req/fire sampled at an edge, grant/denied/conflict/active_cnt registered at that same edge (1 cycle).
// Backpressure: none; requests are levels, a refused load simply shows up in denied until granted.
//
// Ports:
//   clk, reset    clock and async active-low reset
//   req[3:0]      requests: [0] heat, [1] cool, [2] pump, [3] sprinkler
//   fire          fire alarm level
//   grant[3:0]    registered load enables
//   denied[3:0]   registered req & ~grant
//   conflict      registered req[0] & req[1]
//   active_cnt    registered number of budget-counted grants
module load_scheduler
  import load_scheduler_pkg::*;
#(
  parameter int MAX_ACTIVE = 2,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       fire,
  output logic [3:0] grant,
  output logic [3:0] denied,
  output logic       conflict,
  output logic [2:0] active_cnt
);

  localparam logic [2:0] MAX_A = 3'(MAX_ACTIVE);

  logic [3:0]  on_done;
  logic [3:0]  off_done;
  load_state_t st [NUM_LOADS];
  logic [3:0]  kept;
  logic [3:0]  counted;
  logic [2:0]  kept_cnt;
  logic [2:0]  slots;
  logic [3:0]  eligible;
  logic        conflict_nxt;
  load_idx_t   idx;
  logic [3:0]  grant_nxt;
  logic [3:0]  denied_nxt;
  logic [2:0]  active_nxt;

  // The timers track the grant being registered now, so their counts equal the
  // number of edges a load has been continuously on (or off) including this one.
  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_timer
    load_dwell_timer #(
      .CNT_W  (CNT_W),
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF)
    ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .granted (grant_nxt[i]),
      .on_done (on_done[i]),
      .off_done(off_done[i])
    );
  end

  always_comb begin
    kept         = '0;
    eligible     = '0;
    conflict_nxt = req[LD_HEAT] & req[LD_COOL];

    for (int i = 0; i < NUM_LOADS; i++) begin
      if (grant[i]) st[i] = on_done[i]  ? ON_FREE   : ON_HOLD;
      else          st[i] = off_done[i] ? OFF_READY : OFF_HOLD;
      kept[i]     = (st[i] == ON_HOLD) || ((st[i] == ON_FREE) && req[i]);
      eligible[i] = (st[i] == OFF_READY) && req[i];
    end

    // A forced-on sprinkler does not draw on the budget, so it neither occupies
    // a slot nor competes for one while the alarm is up.
    counted  = fire ? (kept & 4'b0111) : kept;
    kept_cnt = popcount4(counted);
    slots    = (kept_cnt >= MAX_A) ? 3'd0 : (MAX_A - kept_cnt);

    // Exclusion is judged against the currently registered grant, not against
    // kept: a heater releasing this edge is still powered until the edge
    // completes, so the cooler must wait one more cycle (and vice versa).
    if (conflict_nxt || grant[LD_COOL]) eligible[LD_HEAT] = 1'b0;
    if (conflict_nxt || grant[LD_HEAT]) eligible[LD_COOL] = 1'b0;
    if (fire)                           eligible[LD_SPRINK] = 1'b0;

    grant_nxt = kept;
    idx       = LD_PUMP;
    for (int p = 0; p < NUM_LOADS; p++) begin
      idx = PRIO_ORDER[p];
      if (eligible[idx] && (slots != 3'd0)) begin
        grant_nxt[idx] = 1'b1;
        slots          = slots - 3'd1;
      end
    end

    // Fire overrides everything above, including minimum on-time of heat/cool.
    if (fire) begin
      grant_nxt[LD_SPRINK] = 1'b1;
      grant_nxt[LD_HEAT]   = 1'b0;
      grant_nxt[LD_COOL]   = 1'b0;
    end

    denied_nxt = req & ~grant_nxt;
    active_nxt = popcount4(grant_nxt) - 3'(grant_nxt[LD_SPRINK] & fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      denied     <= '0;
      conflict   <= 1'b0;
      active_cnt <= '0;
    end else begin
      grant      <= grant_nxt;
      denied     <= denied_nxt;
      conflict   <= conflict_nxt;
      active_cnt <= active_nxt;
    end
  end

endmodule
